// File: rtl/regfile_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler_if
//
// Bundles every non-clock signal of the register file write scheduler:
// the per-requester write requests and the one-hot grant return, the clear
// sequencer command/status pair, and the register file write port.
//
// Signals:
//   req          requester -> scheduler  per-requester write request (level)
//   req_addr     requester -> scheduler  packed destination addresses, slice i
//   req_data     requester -> scheduler  packed write data, slice i
//   grant        scheduler -> requester  one-hot, one-cycle write grant
//   clear_start  requester -> scheduler  pulse that starts the clear sequence
//   clear_busy   scheduler -> requester  clear sequence owns the write port
//   clear_done   scheduler -> requester  pulse during the last clear write
//   write        scheduler -> regfile    register file write enable
//   writeAddress scheduler -> regfile    register file write address
//   writeData    scheduler -> regfile    register file write data
//
// Modports:
//   master  the requester side (execute/write-back stage, testbench)
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface regfile_write_scheduler_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;

  logic                          clear_start;
  logic                          clear_busy;
  logic                          clear_done;

  logic                          write;
  logic [ADDR_WIDTH-1:0]         writeAddress;
  logic [DATA_WIDTH-1:0]         writeData;

  // Requester side: raises requests and the clear command, watches the rest.
  modport master (
    output req, req_addr, req_data, clear_start,
    input  grant, clear_busy, clear_done, write, writeAddress, writeData
  );

  // Scheduler side: owns grant, the clear status and the write port.
  modport slave (
    input  req, req_addr, req_data, clear_start,
    output grant, clear_busy, clear_done, write, writeAddress, writeData
  );

endinterface

// File: rtl/regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler
//
// Owns the single write port of the general register file and shares it
// among NUM_REQ write-back requesters with round-robin arbitration. Also
// contains a clear sequencer that zeroes registers 0..NUM_REGS-1, one per
// cycle, instead of a bulk reset of the array.
//
// Every output is registered: a request sampled at edge E shows up as
// grant/write/writeAddress/writeData during the cycle after E, and the
// register file captures it at edge E+1.
//
// Ports:
//   clock    input  single system clock, rising edge
//   reset_n  input  asynchronous, active-low reset
//   bus      slave modport of regfile_write_scheduler_if carrying requests,
//            grant, clear command/status and the register file write port
// ---------------------------------------------------------------------------
module regfile_write_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  regfile_write_scheduler_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                 state;
  state_t                 stateNext;

  logic [CNT_W-1:0]       clearCount;
  logic [CNT_W-1:0]       countNext;

  logic [PTR_W-1:0]       rrPtr;
  logic [PTR_W-1:0]       ptrNext;

  logic [NUM_REQ-1:0]     grantReg;
  logic [NUM_REQ-1:0]     grantNext;
  logic                   writeReg;
  logic                   writeNext;
  logic [ADDR_WIDTH-1:0]  writeAddrReg;
  logic [ADDR_WIDTH-1:0]  addrNext;
  logic [DATA_WIDTH-1:0]  writeDataReg;
  logic [DATA_WIDTH-1:0]  dataNext;
  logic                   busyReg;
  logic                   busyNext;
  logic                   doneReg;
  logic                   doneNext;

  logic [NUM_REQ-1:0]     eligible;
  logic [PTR_W-1:0]       arbCand;
  logic [PTR_W-1:0]       arbIndex;
  logic                   arbValid;
  logic                   takeGrant;

  logic [ADDR_WIDTH-1:0]  reqAddrArr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  reqDataArr [NUM_REQ];

  // Unpack the flat address/data buses so the winner can be selected by
  // a plain array index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqAddrArr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign reqDataArr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search. The requester on the port right now is masked out:
  // its req is still high when this edge samples it, because it only sees
  // grant during this cycle, so without the mask it would be written twice.
  // The search starts one past the pointer and wraps at NUM_REQ, which is
  // not necessarily a power of two, hence the explicit wrap compare.
  always_comb begin
    eligible = bus.req & ~grantReg;
    arbCand  = rrPtr;
    arbIndex = '0;
    arbValid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arbCand = (arbCand == PTR_LAST) ? '0 : arbCand + PTR_W'(1);
      if (!arbValid && eligible[arbCand]) begin
        arbValid = 1'b1;
        arbIndex = arbCand;
      end
    end
  end

  // Next-state and next-output logic. Outputs default to "port idle":
  // write low, no grant, address/data holding their last values.
  // In IDLE a clear command wins over any request at the same edge. In
  // CLEAR the counter walks the registers; the edge that ends the last
  // clear write goes back to arbitration straight away, so a request held
  // through the whole clear is granted in the very next cycle. A
  // clear_start seen while already clearing is simply not looked at.
  always_comb begin
    stateNext = state;
    countNext = clearCount;
    ptrNext   = rrPtr;
    grantNext = '0;
    writeNext = 1'b0;
    addrNext  = writeAddrReg;
    dataNext  = writeDataReg;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    takeGrant = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.clear_start) begin
          stateNext = CLEAR;
          countNext = '0;
          writeNext = 1'b1;
          addrNext  = '0;
          dataNext  = '0;
          busyNext  = 1'b1;
          doneNext  = (NUM_REGS == 1);
        end else begin
          takeGrant = arbValid;
        end
      end

      CLEAR: begin
        if (clearCount == CLEAR_LAST) begin
          stateNext = IDLE;
          countNext = '0;
          takeGrant = arbValid;
        end else begin
          countNext = clearCount + CNT_W'(1);
          writeNext = 1'b1;
          addrNext  = ADDR_WIDTH'(countNext);
          dataNext  = '0;
          busyNext  = 1'b1;
          doneNext  = (countNext == CLEAR_LAST);
        end
      end

      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase

    // The pointer only moves when somebody actually gets the port, so
    // clears and idle cycles leave the fairness order untouched.
    if (takeGrant) begin
      ptrNext   = arbIndex;
      grantNext = NUM_REQ'(1) << arbIndex;
      writeNext = 1'b1;
      addrNext  = reqAddrArr[arbIndex];
      dataNext  = reqDataArr[arbIndex];
    end
  end

  // State, counter, pointer and all output registers. Reset drops
  // everything at once, including a write or clear in flight, and parks
  // the pointer on the last requester so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clearCount   <= '0;
      rrPtr        <= PTR_LAST;
      grantReg     <= '0;
      writeReg     <= 1'b0;
      writeAddrReg <= '0;
      writeDataReg <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      state        <= stateNext;
      clearCount   <= countNext;
      rrPtr        <= ptrNext;
      grantReg     <= grantNext;
      writeReg     <= writeNext;
      writeAddrReg <= addrNext;
      writeDataReg <= dataNext;
      busyReg      <= busyNext;
      doneReg      <= doneNext;
    end
  end

  assign bus.grant        = grantReg;
  assign bus.write        = writeReg;
  assign bus.writeAddress = writeAddrReg;
  assign bus.writeData    = writeDataReg;
  assign bus.clear_busy   = busyReg;
  assign bus.clear_done   = doneReg;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_scheduler
//
// Drives regfile_write_scheduler through its interface with directed
// scenarios followed by randomized traffic. A reference model steps at each
// rising edge and queues the write it expects on the port in the following
// cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_write_scheduler;

  localparam int NUM_REQ    = 3;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  regfile_write_scheduler_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) bus ();

  regfile_write_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int                    edgeId;
    logic [NUM_REQ-1:0]    grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
  } exp_t;

  exp_t               expQ[$];
  logic [NUM_REQ-1:0] grantLog[$];

  int compared    = 0;
  int mismatched  = 0;
  int edgeNum     = 0;
  int clearWrites = 0;

  // Reference model state: clear progress as "next address to emit"
  // (0 = not clearing), who held the port last cycle, and the requester
  // that most recently won.
  int clearIdx  = 0;
  int lastGrant = -1;
  int lastWin   = NUM_REQ - 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic bit reqBit(input int i);
    return ((bus.req >> i) & 1) != 0;
  endfunction

  // One edge of the behavioural model: the write port carries either the
  // next clear address, the start of a new clear, or the request found
  // first when scanning from just past the last winner, skipping whoever
  // is on the port now.
  task automatic modelStep();
    exp_t e;
    int   chosen;
    bit   leavingClear;
    e.edgeId = edgeNum;
    e.grant  = '0;
    e.addr   = '0;
    e.data   = '0;
    e.busy   = 1'b0;
    e.done   = 1'b0;
    if (clearIdx >= 1 && clearIdx < NUM_REGS) begin
      e.addr = ADDR_WIDTH'(clearIdx);
      e.busy = 1'b1;
      e.done = (clearIdx == NUM_REGS - 1);
      expQ.push_back(e);
      clearIdx++;
      return;
    end
    leavingClear = (clearIdx == NUM_REGS);
    clearIdx = 0;
    if (!leavingClear && bus.clear_start) begin
      e.busy = 1'b1;
      e.done = (NUM_REGS == 1);
      expQ.push_back(e);
      clearIdx  = 1;
      lastGrant = -1;
      return;
    end
    chosen = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (lastWin + k) % NUM_REQ;
      if (chosen < 0 && reqBit(c) && c != lastGrant) chosen = c;
    end
    lastGrant = chosen;
    if (chosen >= 0) begin
      lastWin = chosen;
      e.grant = NUM_REQ'(1) << chosen;
      e.addr  = bus.req_addr[chosen*ADDR_WIDTH +: ADDR_WIDTH];
      e.data  = bus.req_data[chosen*DATA_WIDTH +: DATA_WIDTH];
      expQ.push_back(e);
    end
  endtask

  always @(posedge clock) begin
    edgeNum++;
    if (!reset_n) begin
      clearIdx  = 0;
      lastGrant = -1;
      lastWin   = NUM_REQ - 1;
    end else begin
      modelStep();
    end
  end

  // Monitor: every cycle either the expected write is on the port or the
  // port is quiet.
  always @(negedge clock) begin
    if (!reset_n) begin
      checkOutput("reset_write", 32'(bus.write), 32'd0);
      checkOutput("reset_grant", 32'(bus.grant), 32'd0);
    end else begin
      bit   expWrite;
      exp_t e;
      expWrite = (expQ.size() > 0) && (expQ[0].edgeId == edgeNum);
      if (bus.grant != '0) grantLog.push_back(bus.grant);
      if (bus.clear_busy) clearWrites++;
      checkOutput("write", 32'(bus.write), 32'(expWrite));
      if (expWrite) begin
        e = expQ.pop_front();
        checkOutput("grant",        32'(bus.grant),        32'(e.grant));
        checkOutput("writeAddress", 32'(bus.writeAddress), 32'(e.addr));
        checkOutput("writeData",    32'(bus.writeData),    32'(e.data));
        checkOutput("clear_busy",   32'(bus.clear_busy),   32'(e.busy));
        checkOutput("clear_done",   32'(bus.clear_done),   32'(e.done));
      end else begin
        checkOutput("idle_grant", 32'(bus.grant),      32'd0);
        checkOutput("idle_busy",  32'(bus.clear_busy), 32'd0);
        checkOutput("idle_done",  32'(bus.clear_done), 32'd0);
      end
    end
  end

  // Advance one cycle and update inputs 2ns after the edge. Each requester
  // drops its request once it sees grant (unless told to hold it) and may
  // raise a fresh request with random address/data.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] holdMask,
                               input int newProb, input logic clr);
    @(posedge clock);
    #2;
    bus.clear_start = clr;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [NUM_REQ-1:0] m;
      m = NUM_REQ'(1) << i;
      if ((bus.grant & m) != '0 && (holdMask & m) == '0) bus.req = bus.req & ~m;
      if ((bus.req & m) == '0 && int'($urandom_range(99)) < newProb) begin
        bus.req = bus.req | m;
        bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'($urandom);
        bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
      end
    end
  endtask

  task automatic setReq(input int i, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d);
    bus.req = bus.req | (NUM_REQ'(1) << i);
    bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  initial begin
    bus.req         = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.clear_start = 1'b0;
    reset_n         = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_writeAddress", 32'(bus.writeAddress), 32'd0);
    checkOutput("rst_writeData",    32'(bus.writeData),    32'd0);
    checkOutput("rst_clear_busy",   32'(bus.clear_busy),   32'd0);
    checkOutput("rst_clear_done",   32'(bus.clear_done),   32'd0);
    #1;

    // All three request together, each drops after its grant.
    $display("[TB] all requesters at once after reset");
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      setReq(i, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
    grantLog.delete();
    repeat (5) applyStimulus('0, 0, 1'b0);
    checkOutput("rr_count",  32'(grantLog.size()), 32'd3);
    if (grantLog.size() == 3) begin
      checkOutput("rr_first",  32'(grantLog[0]), 32'b001);
      checkOutput("rr_second", 32'(grantLog[1]), 32'b010);
      checkOutput("rr_third",  32'(grantLog[2]), 32'b100);
    end

    // Requesters 0 and 1 held continuously: grants must alternate.
    $display("[TB] two held requesters");
    setReq(0, 3'd5, 16'hBEEF);
    setReq(1, 3'd2, 16'h1234);
    grantLog.delete();
    repeat (6) applyStimulus(3'b011, 0, 1'b0);
    bus.req = '0;
    repeat (2) applyStimulus('0, 0, 1'b0);
    checkOutput("alt_count", 32'(grantLog.size()), 32'd6);
    if (grantLog.size() >= 3) begin
      checkOutput("alt_0", 32'(grantLog[0]), 32'b001);
      checkOutput("alt_1", 32'(grantLog[1]), 32'b010);
      checkOutput("alt_2", 32'(grantLog[2]), 32'b001);
    end
    for (int i = 1; i < grantLog.size(); i++)
      checkOutput("alt_no_repeat", 32'(grantLog[i]), 32'(~grantLog[i-1] & 3'b011));

    // Plain clear from IDLE.
    $display("[TB] clear sequence");
    clearWrites = 0;
    applyStimulus('0, 0, 1'b1);
    repeat (11) applyStimulus('0, 0, 1'b0);
    checkOutput("clear_len", 32'(clearWrites), 32'(NUM_REGS));

    // Clear and a request at the same edge: clear wins, request waits.
    $display("[TB] clear beats request");
    setReq(1, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
    bus.clear_start = 1'b1;
    grantLog.delete();
    repeat (11) applyStimulus('0, 0, 1'b0);
    checkOutput("pend_count", 32'(grantLog.size()), 32'd1);
    if (grantLog.size() == 1) checkOutput("pend_grant", 32'(grantLog[0]), 32'b010);

    // Re-pulse clear_start while address 3 is on the port.
    $display("[TB] clear re-pulse");
    clearWrites = 0;
    applyStimulus('0, 0, 1'b1);
    repeat (3) applyStimulus('0, 0, 1'b0);
    applyStimulus('0, 0, 1'b1);
    repeat (10) applyStimulus('0, 0, 1'b0);
    checkOutput("repulse_len", 32'(clearWrites), 32'(NUM_REGS));

    // Reset while address 4 is being cleared, with requests 0 and 2 waiting.
    $display("[TB] reset during clear");
    setReq(0, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
    setReq(2, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
    bus.clear_start = 1'b1;
    repeat (5) applyStimulus('0, 0, 1'b0);
    checkOutput("pre_rst_addr", 32'(bus.writeAddress), 32'd4);
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_write", 32'(bus.write),      32'd0);
    checkOutput("async_busy",  32'(bus.clear_busy), 32'd0);
    checkOutput("async_grant", 32'(bus.grant),      32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    grantLog.delete();
    repeat (4) applyStimulus('0, 0, 1'b0);
    checkOutput("post_rst_count", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() == 2) begin
      checkOutput("post_rst_first",  32'(grantLog[0]), 32'b001);
      checkOutput("post_rst_second", 32'(grantLog[1]), 32'b100);
    end

    // Randomized traffic with occasional held requests and clears.
    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_REQ-1:0] hold;
      hold = ($urandom_range(9) == 0) ? NUM_REQ'($urandom) : '0;
      applyStimulus(hold, 40, $urandom_range(99) < 2);
    end
    bus.req = '0;
    repeat (12) applyStimulus('0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 8x16 general register file and shares it among NUM_REQ write-back requesters (ALU, load unit, move/immediate) using round-robin arbitration with a registered grant handshake.
- Contains a clear sequencer that zeroes every register, one per cycle, on command. This replaces a bulk single-cycle reset of the array.
- Sits between the execute/write-back stage and the register file. Its write/writeAddress/writeData outputs connect directly to the register file write inputs.

Parameters:
- NUM_REQ, 3, number of write requesters.
- DATA_WIDTH, 16, register data width.
- ADDR_WIDTH, 3, register address width.
- NUM_REGS, 8, registers walked by the clear sequencer (NUM_REGS <= 2^ADDR_WIDTH).

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request, level.
- req_addr  input  NUM_REQ*ADDR_WIDTH  destination register; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  write data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  NUM_REQ  one-hot, one-cycle pulse; high while that requester's write is on the port.
- clear_start  input  1  pulse; starts the clear sequence.
- clear_busy  output  1  high while the clear sequence owns the port.
- clear_done  output  1  one-cycle pulse, high during the last clear write.
- write  output  1  register file write enable.
- writeAddress  output  ADDR_WIDTH  register file write address.
- writeData  output  DATA_WIDTH  register file write data.

Behaviour:
- Reset (reset_n low, asynchronous): write=0, writeAddress=0, writeData=0, grant=0, clear_busy=0, clear_done=0, state=IDLE, clear counter=0, round-robin pointer=NUM_REQ-1 so requester 0 has first priority. On release, the first arbitration happens at the first rising edge.
- All outputs are registered. A request sampled at edge E drives grant/write/address/data during the cycle after E. The register file captures that write at edge E+1.
- Handshake:
  - The requester holds req, req_addr and req_data stable until it sees grant.
  - At the edge that ends its grant cycle, that requester is excluded from arbitration. This prevents a double write from a stale req.
  - Back-to-back grants to different requesters are allowed, giving one write per cycle.
  - At most one grant per cycle. When nobody is granted, write=0 and writeAddress/writeData hold their last values.
- Round robin:
  - Priority starts at pointer+1 and wraps modulo NUM_REQ.
  - The pointer updates to the granted index only when a grant is issued.
- States IDLE and CLEAR.
  - IDLE: arbitration runs as above. If clear_start=1 at an edge, go to CLEAR with counter=0. clear_start beats any simultaneous req, and no grant is issued at that edge.
  - CLEAR: each cycle write=1, writeAddress=counter, writeData=0, clear_busy=1. The counter increments at each edge.
  - CLEAR, counter=NUM_REGS-1: that cycle also has clear_done=1. At the following edge, return to IDLE and resume arbitration normally; pending requests may be granted at that same edge.
  - CLEAR occupies exactly NUM_REGS cycles.
  - No grants during CLEAR; requests stay pending. clear_start in CLEAR is ignored and does not restart the sequence.
- A clear_start that arrives during the grant cycle of a write is accepted; that write still completes.
- The round-robin pointer is unchanged by CLEAR.
- reset_n asserted mid-CLEAR or mid-grant aborts immediately to the reset values; the interrupted write is not completed.

Test Plan:
- After reset, req=3'b111 held, each requester dropping req after its grant → grants in order 001, 010, 100, one per cycle; writeAddress/writeData match each slice; write=1 for 3 cycles.
- req0 (addr 5, data 16'hBEEF) held continuously with req1 (addr 2, data 16'h1234) → grants alternate 001, 010, 001; req0 is never granted two cycles in a row.
- clear_start pulse in IDLE → writeAddress 0..7, writeData 0, write=1 for 8 consecutive cycles; clear_busy high for those 8; clear_done high only with address 7.
- clear_start and req=3'b010 at the same edge → no grant for 8 cycles; grant=010 in the cycle immediately after clear_done.
- clear_start re-pulsed at clear address 3 → sequence continues 4..7 with no restart; total 8 writes.
- reset_n low at clear address 4 → write, clear_busy and grant drop to 0 asynchronously; after release, req0 is granted first.
